axi_lite_cmd_master: RTL and testbench
======================================

Name: axi_lite_cmd_master

Overview:
Upstream command-to-AXI4-Lite master bridge. It converts single register commands from the debugger command decoder into AXI4-Lite write and read transactions, and it drives the 4x32 memory-mapped slave register file. Only one transaction is outstanding at a time. The bus result is returned on a valid/ready response stream.

Parameters:
ADDR_WIDTH, 4, AXI address width (matches the 4x32 register file).
DATA_WIDTH, 32, AXI data width; the strobe width is DATA_WIDTH/8.
TIMEOUT_CYCLES, 64, number of cycles in a bus phase before timeout_err is raised.

Ports:
clock  in  1  system clock; all logic is rising-edge.
reset_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
cmd_valid  in  1  command offered.
cmd_ready  out  1  command accepted when valid&&ready.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_WIDTH  byte address.
cmd_wdata  in  DATA_WIDTH  write data.
cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
rsp_valid  out  1  result available.
rsp_ready  in  1  result consumed when valid&&ready.
rsp_write  out  1  echoes cmd_write of the completed transaction.
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
rsp_resp  out  2  BRESP or RRESP of the transaction.
timeout_err  out  1  sticky flag: a phase exceeded TIMEOUT_CYCLES.
M_AXI_AWADDR, M_AXI_AWPROT(3), M_AXI_AWVALID  out; M_AXI_AWREADY  in.
M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID  out; M_AXI_WREADY  in.
M_AXI_BRESP(2), M_AXI_BVALID  in; M_AXI_BREADY  out.
M_AXI_ARADDR, M_AXI_ARPROT(3), M_AXI_ARVALID  out; M_AXI_ARREADY  in.
M_AXI_RDATA, M_AXI_RRESP(2), M_AXI_RVALID  in; M_AXI_RREADY  out.

Behaviour:
- Reset values (all outputs registered): every VALID/READY output 0; cmd_ready=1; rsp_valid=0; rsp_* data=0; timeout_err=0; AXI address/data/strb=0; both PROT outputs tied to 3'b000.
- Reset is asynchronous. Asserting reset mid-transaction returns the block to IDLE immediately and drops all VALIDs. The slave is reset by the same signal.
- States: IDLE, WR (AW/W phase), WB (B wait), RA (AR phase), RD (R wait), RSP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch the command, set cmd_ready=0, clear timeout_err and the phase counter.
  - Write: go to WR with AWVALID=WVALID=1 in the next cycle.
  - Read: go to RA with ARVALID=1 in the next cycle.
- WR: AW and W complete independently.
  - AWVALID drops in the cycle after the AWVALID&&AWREADY handshake; WVALID drops in the cycle after the WVALID&&WREADY handshake. Either may come first, or both in the same cycle.
  - Address and data stay stable while their VALID is high.
  - When both handshakes are done, go to WB with BREADY=1.
- WB: on BVALID&&BREADY, capture BRESP, set rsp_write=1 and rsp_rdata=0, drop BREADY, go to RSP.
- RA: on ARVALID&&ARREADY, drop ARVALID, raise RREADY, go to RD.
- RD: on RVALID&&RREADY, capture RDATA/RRESP, set rsp_write=0, drop RREADY, go to RSP.
- RSP: rsp_valid=1 and all rsp_* fields held stable until rsp_ready. On the handshake, rsp_valid=0, cmd_ready=1, go to IDLE. A command cannot be accepted in the same cycle as the response handshake.
- Minimum latency against a zero-wait slave:
  - Write: accept at N, AW/W at N+1, B at N+2, rsp_valid at N+3.
  - Read: accept at N, AR at N+1, R at N+2, rsp_valid at N+3.
- Timeout: an 8-bit-or-wider counter increments each cycle spent in WR, WB, RA or RD and clears on every state change.
  - When it reaches TIMEOUT_CYCLES, timeout_err is set.
  - The block keeps waiting; AXI is never abandoned and no VALID is dropped early.
  - timeout_err stays set until the next accepted command.
- Response codes are passed through unchanged. SLVERR/DECERR produce no special handling.

Test Plan:
- Reset: hold reset_n=0 for 10 cycles -> cmd_ready=1, all AXI VALID/READY=0, rsp_valid=0, timeout_err=0.
- Write then read: write addr 0x4, data 0x12345678, strb 0xF; then read 0x4 -> write rsp has rsp_write=1, rsp_resp=0; read rsp has rsp_rdata=0x12345678; first rsp_valid exactly 3 cycles after accept.
- Byte strobe: write 0xDEADBEEF/0xF to 0x0, then 0x000000FF/0x1, then read 0x0 -> rsp_rdata=0xDEADBEFF.
- Skewed handshake: slave asserts WREADY 3 cycles before AWREADY -> WVALID drops first, AWVALID holds with AWADDR stable, exactly one B accepted, data written correctly.
- Backpressure: hold rsp_ready=0 for 5 cycles after a read of 0xC returning 0x87654321 -> rsp fields stable, cmd_ready=0 throughout; a cmd_valid presented meanwhile is accepted only after the rsp handshake.
- Timeout/reset: slave holds ARREADY=0 for 70 cycles -> timeout_err=1 at 64 cycles, ARVALID stays 1, read completes afterwards. Then assert reset_n=0 mid-WR -> all VALIDs 0 asynchronously, block is back in IDLE after release.

Source files
------------

// File: rtl/axi_lite_cmd_master.sv
// Command-to-AXI4-Lite master bridge: turns single register commands into AXI4-Lite
// write/read transactions, one outstanding at a time, and returns the bus result on a response stream.
module axi_lite_cmd_master #(
   parameter int ADDR_WIDTH     = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_write,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      timeout_err,
   output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                M_AXI_AWPROT,
   output logic                      M_AXI_AWVALID,
   input  logic                      M_AXI_AWREADY,
   output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                      M_AXI_WVALID,
   input  logic                      M_AXI_WREADY,
   input  logic [1:0]                M_AXI_BRESP,
   input  logic                      M_AXI_BVALID,
   output logic                      M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                M_AXI_ARPROT,
   output logic                      M_AXI_ARVALID,
   input  logic                      M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                M_AXI_RRESP,
   input  logic                      M_AXI_RVALID,
   output logic                      M_AXI_RREADY
);

   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WB,
      RA,
      RD,
      RSP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] phase_cnt;
   logic             aw_done;
   logic             w_done;

   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_ARPROT = 3'b000;

   // A channel counts as done once its handshake happens now or has already happened.
   assign aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
   assign w_done  = !M_AXI_WVALID  || M_AXI_WREADY;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         phase_cnt     <= '0;
         cmd_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_write     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_resp      <= 2'b00;
         timeout_err   <= 1'b0;
         M_AXI_AWADDR  <= '0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WDATA   <= '0;
         M_AXI_WSTRB   <= '0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARADDR  <= '0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
      end else begin
         // Bus phases are timed but never abandoned; a state change below overrides the count.
         if (state == WR || state == WB || state == RA || state == RD) begin
            if (phase_cnt != CNT_MAX) begin
               phase_cnt <= phase_cnt + 1'b1;
            end
            if (phase_cnt == CNT_LAST) begin
               timeout_err <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready   <= 1'b0;
                  timeout_err <= 1'b0;
                  phase_cnt   <= '0;
                  if (cmd_write) begin
                     M_AXI_AWADDR  <= cmd_addr;
                     M_AXI_WDATA   <= cmd_wdata;
                     M_AXI_WSTRB   <= cmd_wstrb;
                     M_AXI_AWVALID <= 1'b1;
                     M_AXI_WVALID  <= 1'b1;
                     state         <= WR;
                  end else begin
                     M_AXI_ARADDR  <= cmd_addr;
                     M_AXI_ARVALID <= 1'b1;
                     state         <= RA;
                  end
               end
            end

            WR: begin
               if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                  M_AXI_AWVALID <= 1'b0;
               end
               if (M_AXI_WVALID && M_AXI_WREADY) begin
                  M_AXI_WVALID <= 1'b0;
               end
               if (aw_done && w_done) begin
                  M_AXI_BREADY <= 1'b1;
                  phase_cnt    <= '0;
                  state        <= WB;
               end
            end

            WB: begin
               if (M_AXI_BVALID) begin
                  rsp_resp     <= M_AXI_BRESP;
                  rsp_write    <= 1'b1;
                  rsp_rdata    <= '0;
                  rsp_valid    <= 1'b1;
                  M_AXI_BREADY <= 1'b0;
                  phase_cnt    <= '0;
                  state        <= RSP;
               end
            end

            RA: begin
               if (M_AXI_ARREADY) begin
                  M_AXI_ARVALID <= 1'b0;
                  M_AXI_RREADY  <= 1'b1;
                  phase_cnt     <= '0;
                  state         <= RD;
               end
            end

            RD: begin
               if (M_AXI_RVALID) begin
                  rsp_rdata    <= M_AXI_RDATA;
                  rsp_resp     <= M_AXI_RRESP;
                  rsp_write    <= 1'b0;
                  rsp_valid    <= 1'b1;
                  M_AXI_RREADY <= 1'b0;
                  phase_cnt    <= '0;
                  state        <= RSP;
               end
            end

            RSP: begin
               // cmd_ready rises only after the handshake, so no command overlaps it.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Randomized self-checking bench for axi_lite_cmd_master with a 4x32 register-file slave
// and a behavioural register/latency model.
module tb_axi_lite_cmd_master;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [3:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic        rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        timeout_err;
   logic [3:0]  M_AXI_AWADDR;
   logic [2:0]  M_AXI_AWPROT;
   logic        M_AXI_AWVALID;
   logic        M_AXI_AWREADY;
   logic [31:0] M_AXI_WDATA;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_WVALID;
   logic        M_AXI_WREADY;
   logic [1:0]  M_AXI_BRESP;
   logic        M_AXI_BVALID;
   logic        M_AXI_BREADY;
   logic [3:0]  M_AXI_ARADDR;
   logic [2:0]  M_AXI_ARPROT;
   logic        M_AXI_ARVALID;
   logic        M_AXI_ARREADY;
   logic [31:0] M_AXI_RDATA;
   logic [1:0]  M_AXI_RRESP;
   logic        M_AXI_RVALID;
   logic        M_AXI_RREADY;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   axi_lite_cmd_master #(
      .ADDR_WIDTH(4),
      .DATA_WIDTH(32),
      .TIMEOUT_CYCLES(64)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout_err(timeout_err),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      end
      return r;
   endfunction

   // Slave answers misaligned addresses with SLVERR so response pass-through is exercised.
   function automatic logic [1:0] resp_for(input logic [3:0] a);
      return (a[1:0] != 2'b00) ? 2'b10 : 2'b00;
   endfunction

   // Register-file slave with programmable ready delays on AW, W and AR.
   logic [31:0] slv_mem [4];
   int          aw_delay = 0, w_delay = 0, ar_delay = 0;
   int          aw_cnt, w_cnt, ar_cnt;
   int          b_count = 0;
   logic        aw_got, w_got;
   logic [3:0]  aw_addr_l;
   logic [31:0] w_data_l;
   logic [3:0]  w_strb_l;
   logic        aw_hs, w_hs, ar_hs, have_aw, have_w;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;

   assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_delay);
   assign M_AXI_WREADY  = M_AXI_WVALID  && (w_cnt  >= w_delay);
   assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_delay);
   assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_hs    = M_AXI_WVALID  && M_AXI_WREADY;
   assign ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
   assign have_aw = aw_got || aw_hs;
   assign have_w  = w_got  || w_hs;
   assign wr_addr = aw_got ? aw_addr_l : M_AXI_AWADDR;
   assign wr_data = w_got  ? w_data_l  : M_AXI_WDATA;
   assign wr_strb = w_got  ? w_strb_l  : M_AXI_WSTRB;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0;
         aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0;
         M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
         M_AXI_RVALID <= 1'b0; M_AXI_RDATA <= '0; M_AXI_RRESP <= 2'b00;
         for (int i = 0; i < 4; i++) slv_mem[i] <= '0;
      end else begin
         if (aw_hs) aw_cnt <= 0; else if (M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
         if (w_hs)  w_cnt  <= 0; else if (M_AXI_WVALID)  w_cnt  <= w_cnt + 1;
         if (ar_hs) ar_cnt <= 0; else if (M_AXI_ARVALID) ar_cnt <= ar_cnt + 1;
         if (have_aw && have_w) begin
            slv_mem[wr_addr[3:2]] <= merge_bytes(slv_mem[wr_addr[3:2]], wr_data, wr_strb);
            M_AXI_BVALID <= 1'b1;
            M_AXI_BRESP  <= resp_for(wr_addr);
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end else begin
            if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= M_AXI_AWADDR; end
            if (w_hs)  begin w_got <= 1'b1; w_data_l <= M_AXI_WDATA; w_strb_l <= M_AXI_WSTRB; end
         end
         if (M_AXI_BVALID && M_AXI_BREADY) begin
            M_AXI_BVALID <= 1'b0;
            b_count <= b_count + 1;
         end
         if (ar_hs) begin
            M_AXI_RVALID <= 1'b1;
            M_AXI_RDATA  <= slv_mem[M_AXI_ARADDR[3:2]];
            M_AXI_RRESP  <= resp_for(M_AXI_ARADDR);
         end else if (M_AXI_RVALID && M_AXI_RREADY) begin
            M_AXI_RVALID <= 1'b0;
         end
      end
   end

   // Reference model: register contents as the command stream says they should be.
   logic [31:0] model_mem [4];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one command, check its response, optionally stall the response for hold cycles
   // while a read of address 0 is presented on the command port.
   task automatic do_cmd(input bit wr, input logic [3:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int hold,
                         output int lat, output logic [31:0] rd);
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      int          k;
      exp_resp = resp_for(addr);
      if (wr) begin
         exp_rdata = '0;
         model_mem[addr[3:2]] = merge_bytes(model_mem[addr[3:2]], data, strb);
      end else begin
         exp_rdata = model_mem[addr[3:2]];
      end
      rd = '0;
      cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 100) begin @(posedge clock); #1; k++; end
      if (!cmd_ready) begin
         check("cmd_accept_bound", 0, 1);
         cmd_valid = 1'b0; lat = -1;
         return;
      end
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 300) begin @(posedge clock); #1; lat++; end
      if (!rsp_valid) begin
         check("rsp_bound", 0, 1);
         lat = -1;
         return;
      end
      rd = rsp_rdata;
      check("rsp_write", rsp_write, wr);
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("rsp_resp", rsp_resp, exp_resp);
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h0;
         @(posedge clock); #1;
         check("hold_rsp_valid", rsp_valid, 1);
         check("hold_rsp_rdata", rsp_rdata, exp_rdata);
         check("hold_rsp_resp", rsp_resp, exp_resp);
         check("hold_cmd_ready", cmd_ready, 0);
         check("hold_no_ar", M_AXI_ARVALID, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      check("rsp_valid_drop", rsp_valid, 0);
      if (hold > 0) begin
         check("post_hold_no_ar", M_AXI_ARVALID, 0);
         check("post_hold_cmd_ready", cmd_ready, 1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          lat;
      logic [31:0] rd;
      int          bc0;
      for (int i = 0; i < 4; i++) model_mem[i] = '0;

      reset_n = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_timeout", timeout_err, 0);
      check("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 0);
      check("rst_readys", {M_AXI_BREADY, M_AXI_RREADY}, 0);
      check("rst_prot", {M_AXI_AWPROT, M_AXI_ARPROT}, 0);
      check("rst_addr_data", {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB}, 0);
      reset_n = 1'b1;
      @(posedge clock); #1;

      // Write then read back with a zero-wait slave.
      do_cmd(1, 4'h4, 32'h1234_5678, 4'hF, 0, lat, rd);
      check("wr_latency", lat, 3);
      do_cmd(0, 4'h4, '0, '0, 0, lat, rd);
      check("rd_latency", lat, 3);
      check("rd_value", rd, 32'h1234_5678);

      // Byte strobes.
      do_cmd(1, 4'h0, 32'hDEAD_BEEF, 4'hF, 0, lat, rd);
      do_cmd(1, 4'h0, 32'h0000_00FF, 4'h1, 0, lat, rd);
      do_cmd(0, 4'h0, '0, '0, 0, lat, rd);
      check("strobe_value", rd, 32'hDEAD_BEFF);

      // W handshakes three cycles before AW.
      aw_delay = 3; w_delay = 0;
      bc0 = b_count;
      fork
         do_cmd(1, 4'h8, 32'hA5A5_5A5A, 4'hF, 0, lat, rd);
         begin
            @(posedge clock); #1;
            check("skew_aw_up", M_AXI_AWVALID, 1);
            check("skew_w_up", M_AXI_WVALID, 1);
            @(posedge clock); #1;
            check("skew_w_drop", M_AXI_WVALID, 0);
            check("skew_aw_hold", M_AXI_AWVALID, 1);
            repeat (2) @(posedge clock);
            #1;
            check("skew_aw_still", M_AXI_AWVALID, 1);
            check("skew_awaddr", M_AXI_AWADDR, 4'h8);
         end
      join
      check("skew_latency", lat, 6);
      check("skew_one_b", b_count - bc0, 1);
      aw_delay = 0;
      do_cmd(0, 4'h8, '0, '0, 0, lat, rd);
      check("skew_value", rd, 32'hA5A5_5A5A);

      // Response backpressure with a command waiting.
      do_cmd(1, 4'hC, 32'h8765_4321, 4'hF, 0, lat, rd);
      do_cmd(0, 4'hC, '0, '0, 5, lat, rd);
      check("bp_value", rd, 32'h8765_4321);
      do_cmd(0, 4'h0, '0, '0, 0, lat, rd);
      check("bp_pending_value", rd, 32'hDEAD_BEFF);

      // Slow AR: timeout flag rises but the read still completes.
      ar_delay = 70;
      fork
         do_cmd(0, 4'hC, '0, '0, 0, lat, rd);
         begin
            repeat (60) @(posedge clock);
            #1;
            check("to_not_yet", timeout_err, 0);
            check("to_ar_held60", M_AXI_ARVALID, 1);
            repeat (6) @(posedge clock);
            #1;
            check("to_set", timeout_err, 1);
            check("to_ar_held66", M_AXI_ARVALID, 1);
         end
      join
      check("to_latency", lat, 73);
      check("to_value", rd, 32'h8765_4321);
      check("to_sticky", timeout_err, 1);
      ar_delay = 0;
      do_cmd(0, 4'h4, '0, '0, 0, lat, rd);
      check("to_cleared", timeout_err, 0);

      // Randomized traffic with random slave ready delays.
      for (int n = 0; n < 30; n++) begin
         bit          wr;
         logic [3:0]  a;
         logic [31:0] d;
         logic [3:0]  s;
         int          exp_lat;
         aw_delay = $urandom_range(0, 3);
         w_delay  = $urandom_range(0, 3);
         ar_delay = $urandom_range(0, 3);
         wr = 1'($urandom_range(0, 1));
         a  = 4'($urandom_range(0, 15));
         d  = $urandom;
         s  = 4'($urandom_range(0, 15));
         exp_lat = 3 + (wr ? ((aw_delay > w_delay) ? aw_delay : w_delay) : ar_delay);
         do_cmd(wr, a, d, s, 0, lat, rd);
         check("rand_latency", lat, exp_lat);
      end
      aw_delay = 0; w_delay = 0; ar_delay = 0;

      // Asynchronous reset in the middle of a write.
      aw_delay = 20; w_delay = 20;
      cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
      cmd_valid = 1'b1;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      @(posedge clock); #1;
      check("mid_wr_aw", M_AXI_AWVALID, 1);
      check("mid_wr_w", M_AXI_WVALID, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 0);
      check("async_rst_readys", {M_AXI_BREADY, M_AXI_RREADY}, 0);
      check("async_rst_cmd_ready", cmd_ready, 1);
      for (int i = 0; i < 4; i++) model_mem[i] = '0;
      aw_delay = 0; w_delay = 0;
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      check("post_rst_idle", cmd_ready, 1);
      check("post_rst_aw", M_AXI_AWVALID, 0);
      do_cmd(0, 4'h4, '0, '0, 0, lat, rd);
      check("post_rst_latency", lat, 3);
      do_cmd(1, 4'h4, 32'h0BAD_F00D, 4'hF, 0, lat, rd);
      do_cmd(0, 4'h4, '0, '0, 0, lat, rd);
      check("post_rst_value", rd, 32'h0BAD_F00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
